// File: rtl/rr_arb_mux.sv
// N-input arbitrated multiplexer: round-robin or fixed-priority grant feeding a
// one-entry registered valid/ready output stage that also records the winning channel.
module rr_arb_mux #(
  parameter int BIT_WIDTH = 32,
  parameter int NUM_IN    = 3,
  parameter int ARB_MODE  = 0,
  parameter int SEL_W     = $clog2(NUM_IN)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_IN-1:0]           in_valid,
  input  logic [NUM_IN*BIT_WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]           in_ready,
  output logic                        out_valid,
  output logic [BIT_WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]            out_sel,
  input  logic                        out_ready
);

  logic                 out_valid_q, out_valid_d;
  logic [BIT_WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0]     out_sel_q,   out_sel_d;
  logic [SEL_W-1:0]     ptr_q,       ptr_d;

  logic [SEL_W-1:0]     start_s;
  logic [SEL_W-1:0]     grant_idx_s;
  logic [NUM_IN-1:0]    grant_s;
  logic                 found_s;
  logic                 load_en_s;
  logic                 xfer_s;

  // Grant search: walk channels starting at the priority pointer, modulo NUM_IN.
  always_comb begin
    grant_s     = {NUM_IN{1'b0}};
    grant_idx_s = {SEL_W{1'b0}};
    found_s     = 1'b0;
    if (ARB_MODE == 1) begin
      start_s = {SEL_W{1'b0}};
    end else begin
      start_s = ptr_q;
    end
    for (int k = 0; k < NUM_IN; k++) begin
      logic [SEL_W-1:0] idx_v;
      idx_v = SEL_W'((int'(start_s) + k) % NUM_IN);
      if (!found_s && in_valid[idx_v]) begin
        grant_s[idx_v] = 1'b1;
        grant_idx_s    = idx_v;
        found_s        = 1'b1;
      end else begin
        grant_s[idx_v] = grant_s[idx_v];
      end
    end
  end

  // Handshake qualification; ready is withheld while reset is asserted.
  always_comb begin
    load_en_s = !out_valid_q || out_ready;
    if (load_en_s && rst_n) begin
      in_ready = grant_s;
    end else begin
      in_ready = {NUM_IN{1'b0}};
    end
    xfer_s = |(in_valid & in_ready);
  end

  // Next state of the output register and the round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (xfer_s) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[grant_idx_s*BIT_WIDTH +: BIT_WIDTH];
      out_sel_d   = grant_idx_s;
      if (ARB_MODE == 1) begin
        ptr_d = {SEL_W{1'b0}};
      end else if (grant_idx_s == SEL_W'(NUM_IN - 1)) begin
        ptr_d = {SEL_W{1'b0}};
      end else begin
        ptr_d = grant_idx_s + {{(SEL_W-1){1'b0}}, 1'b1};
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= {BIT_WIDTH{1'b0}};
      out_sel_q   <= {SEL_W{1'b0}};
      ptr_q       <= {SEL_W{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a round-robin instance and a fixed-priority
// instance share one stimulus stream; expected values are hand-computed.
module tb_rr_arb_mux;

  localparam int BW = 32;
  localparam int NI = 3;
  localparam int SW = $clog2(NI);

  logic              clk;
  logic              rst_n;
  logic [NI-1:0]     in_valid;
  logic [NI*BW-1:0]  in_data;
  logic              out_ready;

  logic [NI-1:0]     rr_in_ready, fp_in_ready;
  logic              rr_out_valid, fp_out_valid;
  logic [BW-1:0]     rr_out_data, fp_out_data;
  logic [SW-1:0]     rr_out_sel, fp_out_sel;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [BW-1:0] exp_data [3];
  logic [NI-1:0] exp_rdy  [3];

  rr_arb_mux #(.BIT_WIDTH(BW), .NUM_IN(NI), .ARB_MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rr_in_ready), .out_valid(rr_out_valid), .out_data(rr_out_data),
    .out_sel(rr_out_sel), .out_ready(out_ready)
  );

  rr_arb_mux #(.BIT_WIDTH(BW), .NUM_IN(NI), .ARB_MODE(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(fp_in_ready), .out_valid(fp_out_valid), .out_data(fp_out_data),
    .out_sel(fp_out_sel), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_data[0] = 32'hAA; exp_data[1] = 32'hBB; exp_data[2] = 32'hCC;
    exp_rdy[0]  = 3'b001; exp_rdy[1]  = 3'b010; exp_rdy[2]  = 3'b100;

    // Reset held with all requests pending
    rst_n     = 1'b0;
    in_valid  = 3'b111;
    in_data   = {32'hCC, 32'hBB, 32'hAA};
    out_ready = 1'b1;
    #3;
    chk("rst_valid", 64'(rr_out_valid), 64'd0);
    chk("rst_data",  64'(rr_out_data),  64'd0);
    chk("rst_sel",   64'(rr_out_sel),   64'd0);
    chk("rst_ready", 64'(rr_in_ready),  64'd0);
    tick();
    chk("rst_ready_edge", 64'(rr_in_ready), 64'd0);
    chk("rst_valid_edge", 64'(rr_out_valid), 64'd0);

    // Round-robin with all channels valid
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 7; i++) begin
      chk("rr_ready", 64'(rr_in_ready), 64'(exp_rdy[i % 3]));
      tick();
      chk("rr_valid", 64'(rr_out_valid), 64'd1);
      chk("rr_data",  64'(rr_out_data),  64'(exp_data[i % 3]));
      chk("rr_sel",   64'(rr_out_sel),   64'(i % 3));
    end

    // Backpressure while holding AA
    out_ready = 1'b0;
    #1;
    chk("bp_ready0", 64'(rr_in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", 64'(rr_out_valid), 64'd1);
      chk("bp_data",  64'(rr_out_data),  64'hAA);
      chk("bp_ready", 64'(rr_in_ready),  64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_ready", 64'(rr_in_ready), 64'b010);
    tick();
    chk("bp_rel_data", 64'(rr_out_data), 64'hBB);
    chk("bp_rel_sel",  64'(rr_out_sel),  64'd1);

    // Sparse: ch2 alone, then ch0+ch2 after pointer wrap
    in_valid = 3'b100;
    in_data  = {32'h33, 32'hBB, 32'hAA};
    #1;
    chk("sp_ready2", 64'(rr_in_ready), 64'b100);
    tick();
    chk("sp_sel2",  64'(rr_out_sel),  64'd2);
    chk("sp_data2", 64'(rr_out_data), 64'h33);
    in_valid = 3'b101;
    #1;
    chk("sp_ready_wrap", 64'(rr_in_ready), 64'b001);
    tick();
    chk("sp_sel_wrap",  64'(rr_out_sel),  64'd0);
    chk("sp_data_wrap", 64'(rr_out_data), 64'hAA);

    // Drain to empty
    in_valid = 3'b010;
    in_data  = {32'hCC, 32'h55, 32'hAA};
    tick();
    chk("dr_valid1", 64'(rr_out_valid), 64'd1);
    chk("dr_data1",  64'(rr_out_data),  64'h55);
    chk("dr_sel1",   64'(rr_out_sel),   64'd1);
    in_valid = 3'b000;
    #1;
    chk("dr_ready_none", 64'(rr_in_ready), 64'd0);
    tick();
    chk("dr_valid0", 64'(rr_out_valid), 64'd0);
    chk("dr_data0",  64'(rr_out_data),  64'h55);
    chk("dr_sel0",   64'(rr_out_sel),   64'd1);
    tick();
    chk("dr_valid0b", 64'(rr_out_valid), 64'd0);
    chk("dr_data0b",  64'(rr_out_data),  64'h55);

    // Fixed priority always picks ch0; round-robin ends with ptr at 2
    in_valid = 3'b111;
    in_data  = {32'hCC, 32'hBB, 32'hAA};
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fp_ready", 64'(fp_in_ready), 64'b001);
      tick();
      chk("fp_sel",   64'(fp_out_sel),   64'd0);
      chk("fp_data",  64'(fp_out_data),  64'hAA);
      chk("fp_valid", 64'(fp_out_valid), 64'd1);
    end
    chk("pre_rst_valid", 64'(rr_out_valid), 64'd1);
    chk("pre_rst_data",  64'(rr_out_data),  64'hBB);

    // Asynchronous reset mid-operation
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(rr_out_valid), 64'd0);
    chk("mid_rst_data",  64'(rr_out_data),  64'd0);
    chk("mid_rst_ready", 64'(rr_in_ready),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 64'(rr_in_ready), 64'b001);
    tick();
    chk("post_rst_sel",  64'(rr_out_sel),  64'd0);
    chk("post_rst_data", 64'(rr_out_data), 64'hAA);
    chk("post_rst_next", 64'(rr_in_ready), 64'b010);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
